md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameter WIDTH, 32, operand/result width.
REQ-002 Parameter WDOG, 15, max cycles in WAIT before abort; SHALL be >= 11.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  pipeline presents an MD-class instruction.
REQ-006 req_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo.
REQ-007 req_srca, req_srcb  in  WIDTH  rs/rt operands.
REQ-008 int_req  in  1  interrupt/exception pending; cancels issue.
REQ-009 req_ready  out  1  controller can accept this cycle.
REQ-010 stall  out  1  freeze pipeline front-end.
REQ-011 md_start, md_op[2:0], md_srca, md_srcb, md_int_req  out  to MD unit.
REQ-012 md_busy  in  1; md_hi, md_lo  in  WIDTH  from MD unit.
REQ-013 rd_valid  out  1; rd_data  out  WIDTH  mfhi/mflo result.
REQ-014 wdog_err  out  1  sticky watchdog flag.

Function
REQ-015 States: IDLE, ISSUE, WAIT, READ. req_ready SHALL be 1 only in IDLE with int_req=0.
REQ-016 stall SHALL equal req_valid & ~req_ready (combinational).
REQ-017 Accept = req_valid & req_ready; op and operands SHALL be registered on accept.
REQ-018 Accept of op 000-101 SHALL go to ISSUE; op 110/111 SHALL go to READ.
REQ-019 ISSUE lasts exactly 1 cycle: md_op = registered op; md_start = 1 for ops 000-011, 0 for 100/101; then WAIT for 000-011, IDLE for 100/101.
REQ-020 Outside ISSUE, md_start=0 and md_op=000 (never 100/101, which write HI/LO unconditionally).
REQ-021 WAIT SHALL exit to IDLE on the first cycle md_busy=0 (busy rises the cycle after start; HI/LO valid on exit).
REQ-022 READ: rd_data = md_hi (110) or md_lo (111), rd_valid=1 for exactly 1 cycle, then IDLE; latency accept->rd_valid = 1 cycle.
REQ-023 md_int_req SHALL equal int_req (pass-through).
REQ-024 int_req=1 in ISSUE: md_start still driven, MD unit ignores it; controller SHALL return to IDLE, no WAIT.
REQ-025 int_req in WAIT or READ SHALL NOT alter the sequence (MD op completes).
REQ-026 5-bit WAIT counter, cleared on WAIT entry; at count == WDOG with md_busy=1, SHALL set wdog_err and go to IDLE.
REQ-027 wdog_err SHALL clear only on reset.
REQ-028 Back-to-back: request held during WAIT SHALL be accepted in the first IDLE cycle after exit.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, counter 0, all outputs 0 (req_ready 0 while in reset).
REQ-030 Reset mid-WAIT SHALL abandon the op; MD unit is reset by the same net.

Structure
REQ-031 Op encodings (MD_MULT..MD_MFLO) and state encoding SHALL live in shared package md_pkg.
REQ-032 No sub-module; FSM and watchdog counter inline. MD unit instantiated at the parent level.

Verification
REQ-033 mult, srca=0xFFFFFFFE, srcb=3 -> one 1-cycle md_start, stall during WAIT; then mflo -> rd_data=0xFFFFFFFA, mfhi -> 0xFFFFFFFF.
REQ-034 divu 7/2, mfhi held from next cycle -> stall high until busy falls; rd_valid with rd_data=1; mflo -> 3.
REQ-035 mthi 0x12345678 then mfhi -> md_start stays 0, md_op=100 for 1 cycle, rd_data=0x12345678.
REQ-036 mult accepted, int_req=1 in ISSUE -> no WAIT, IDLE next cycle; HI/LO unchanged.
REQ-037 md_busy stuck 1 after start -> wdog_err=1 after 15 WAIT cycles, IDLE, flag persists until reset.
REQ-038 reset asserted mid-WAIT of div -> outputs 0 immediately; after release, req_ready=1.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide controller: HI/LO op encodings,
// controller state encoding and small op-classification helpers.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101,
        MD_MFHI  = 3'b110,
        MD_MFLO  = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_READ  = 2'd3
    } md_state_e;

    localparam int WAIT_CNT_W = 5;

    // Multiply/divide ops start the unit; mthi/mtlo only write a register.
    function automatic logic is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic is_read(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/md_ctrl.sv
// md_ctrl: issue controller between the pipeline and the multiply/divide unit.
// Stalls the front end while the unit is busy, relays HI/LO reads, aborts hung ops.
module md_ctrl
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int WDOG  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_srca,
    input  logic [WIDTH-1:0] req_srcb,
    input  logic             int_req,
    output logic             req_ready,
    output logic             stall,
    output logic             md_start,
    output logic [2:0]       md_op,
    output logic [WIDTH-1:0] md_srca,
    output logic [WIDTH-1:0] md_srcb,
    output logic             md_int_req,
    input  logic             md_busy,
    input  logic [WIDTH-1:0] md_hi,
    input  logic [WIDTH-1:0] md_lo,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             wdog_err
);

    localparam logic [WAIT_CNT_W-1:0] WDOG_CNT = WAIT_CNT_W'(WDOG);

    md_state_e             state, state_n;
    md_op_e                op_q;
    logic [WIDTH-1:0]      srca_q, srcb_q;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  accept;
    logic                  wdog_hit;

    // Gating with reset keeps req_ready low while the block is held in reset.
    assign req_ready  = reset & (state == ST_IDLE) & ~int_req;
    assign accept     = req_valid & req_ready;
    assign stall      = req_valid & ~req_ready;
    assign md_int_req = int_req;
    assign md_srca    = srca_q;
    assign md_srcb    = srcb_q;
    assign wdog_hit   = (state == ST_WAIT) & md_busy & (wait_cnt == WDOG_CNT);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            op_q     <= MD_MULT;
            srca_q   <= '0;
            srcb_q   <= '0;
            wait_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q   <= md_op_e'(req_op);
                srca_q <= req_srca;
                srcb_q <= req_srcb;
            end
            // Zero on every cycle outside WAIT, so it starts from 0 on entry.
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
            if (wdog_hit) begin
                wdog_err <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n  = state;
        md_start = 1'b0;
        md_op    = MD_MULT;
        rd_valid = 1'b0;
        rd_data  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = is_read(req_op) ? ST_READ : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // An interrupt here makes the unit drop the start; skip WAIT.
                md_start = is_arith(op_q);
                md_op    = op_q;
                state_n  = (is_arith(op_q) && !int_req) ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (!md_busy || wdog_hit) begin
                    state_n = ST_IDLE;
                end
            end
            ST_READ: begin
                rd_valid = 1'b1;
                rd_data  = (op_q == MD_MFHI) ? md_hi : md_lo;
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: behavioural MD unit stub plus an
// architectural HI/LO reference driven by directed and random instructions.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int WIDTH = 32;
    localparam int WDOG  = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic [2:0]       req_op = '0;
    logic [WIDTH-1:0] req_srca = '0;
    logic [WIDTH-1:0] req_srcb = '0;
    logic             int_req = 1'b0;
    logic             req_ready, stall, md_start, md_int_req;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] md_srca, md_srcb, rd_data;
    logic             rd_valid, wdog_err;

    logic [WIDTH-1:0] mdu_hi, mdu_lo;
    logic             mdu_busy;
    int               mdu_left;
    int               mdu_lat = 1;
    bit               mdu_stuck = 1'b0;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [WIDTH-1:0] exp_hi = '0;
    logic [WIDTH-1:0] exp_lo = '0;

    always #5 clk = ~clk;

    md_ctrl #(.WIDTH(WIDTH), .WDOG(WDOG)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_srca(req_srca), .req_srcb(req_srcb),
        .int_req(int_req), .req_ready(req_ready), .stall(stall),
        .md_start(md_start), .md_op(md_op), .md_srca(md_srca), .md_srcb(md_srcb),
        .md_int_req(md_int_req), .md_busy(mdu_busy), .md_hi(mdu_hi), .md_lo(mdu_lo),
        .rd_valid(rd_valid), .rd_data(rd_data), .wdog_err(wdog_err)
    );

    // Architectural effect of one MD instruction on {HI, LO}.
    function automatic logic [63:0] md_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            3'd0:    return sa * sb;
            3'd1:    return ua * ub;
            3'd2:    return {32'(sa % sb), 32'(sa / sb)};
            3'd3:    return {32'(ua % ub), 32'(ua / ub)};
            3'd4:    return {a, lo};
            3'd5:    return {hi, a};
            default: return {hi, lo};
        endcase
    endfunction

    // Multiply/divide unit stub: result lands at start, busy for mdu_lat cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdu_hi   <= '0;
            mdu_lo   <= '0;
            mdu_busy <= 1'b0;
            mdu_left <= 0;
        end else if (md_start && !md_int_req) begin
            {mdu_hi, mdu_lo} <= md_result(md_op, md_srca, md_srcb, mdu_hi, mdu_lo);
            mdu_busy <= 1'b1;
            mdu_left <= mdu_lat;
        end else if ((md_op == MD_MTHI || md_op == MD_MTLO) && !md_int_req) begin
            {mdu_hi, mdu_lo} <= md_result(md_op, md_srca, md_srcb, mdu_hi, mdu_lo);
        end else if (mdu_busy && !mdu_stuck) begin
            if (mdu_left <= 1) mdu_busy <= 1'b0;
            else mdu_left <= mdu_left - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 64) begin
            tick();
            n++;
        end
        check("ready_timeout", req_ready, 1'b1);
    endtask

    // Issue one instruction; optionally raise int_req in ISSUE, or hold a
    // follow-up request (hold_op) asserted for the whole WAIT phase.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input bit irq, input bit hold, input logic [2:0] hold_op);
        int n;
        wait_ready();
        mdu_lat   = lat;
        req_valid = 1'b1;
        req_op    = op;
        req_srca  = a;
        req_srcb  = b;
        #1;
        check("stall_on_accept", stall, 1'b0);
        tick();
        req_valid = 1'b0;
        req_op    = '0;
        if (is_read(op)) begin
            check("rd_valid", rd_valid, 1'b1);
            check("rd_data", rd_data, (op == MD_MFHI) ? exp_hi : exp_lo);
            tick();
            check("rd_valid_1cyc", rd_valid, 1'b0);
            check("idle_after_read", req_ready, 1'b1);
        end else begin
            int_req = irq;
            #1;
            check("issue_start", md_start, is_arith(op));
            check("issue_op", md_op, op);
            check("issue_srca", md_srca, a);
            check("md_int_req", md_int_req, irq);
            if (is_arith(op)) check("issue_srcb", md_srcb, b);
            if (!irq) {exp_hi, exp_lo} = md_result(op, a, b, exp_hi, exp_lo);
            tick();
            int_req = 1'b0;
            #1;
            check("post_issue_start", md_start, 1'b0);
            check("post_issue_op", md_op, 3'b000);
            if (is_arith(op) && !irq) begin
                n = 0;
                req_valid = hold;
                req_op    = hold_op;
                while (!req_ready && n < 64) begin
                    #1;
                    check("wait_stall", stall, hold);
                    tick();
                    n++;
                end
                check("wait_cycles", n, lat + 1);
            end else begin
                check("idle_after_issue", req_ready, 1'b1);
            end
        end
    endtask

    initial begin
        int n;
        logic [2:0]  op;
        logic [31:0] a, b;

        // Reset state
        #1;
        check("rst_ready", req_ready, 1'b0);
        check("rst_outputs", {md_start, md_op, rd_valid, stall, wdog_err}, '0);
        check("rst_operands", {md_srca, md_srcb, rd_data}, '0);
        #22 reset = 1'b1;
        tick();
        check("ready_after_reset", req_ready, 1'b1);
        int_req = 1'b1;
        req_valid = 1'b1;
        #1;
        check("ready_blocked_by_int", {req_ready, stall}, 2'b01);
        int_req = 1'b0;
        req_valid = 1'b0;

        // mult -2 * 3, with a read held through WAIT
        do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 3, 1'b0, 1'b1, MD_MFLO);
        do_op(MD_MFLO, 0, 0, 1, 1'b0, 1'b0, 3'b000);
        check("mult_lo_const", exp_lo, 32'hFFFF_FFFA);
        do_op(MD_MFHI, 0, 0, 1, 1'b0, 1'b0, 3'b000);
        check("mult_hi_const", exp_hi, 32'hFFFF_FFFF);

        // divu 7 / 2 with mfhi held back-to-back
        do_op(MD_DIVU, 32'd7, 32'd2, 4, 1'b0, 1'b1, MD_MFHI);
        do_op(MD_MFHI, 0, 0, 1, 1'b0, 1'b0, 3'b000);
        do_op(MD_MFLO, 0, 0, 1, 1'b0, 1'b0, 3'b000);
        check("divu_consts", {exp_hi, exp_lo}, {32'd1, 32'd3});

        // mthi then mfhi
        do_op(MD_MTHI, 32'h1234_5678, 32'd0, 1, 1'b0, 1'b0, 3'b000);
        do_op(MD_MFHI, 0, 0, 1, 1'b0, 1'b0, 3'b000);

        // mult cancelled by interrupt in ISSUE: HI/LO must be unchanged
        do_op(MD_MULT, 32'd5, 32'd7, 2, 1'b1, 1'b0, 3'b000);
        do_op(MD_MFHI, 0, 0, 1, 1'b0, 1'b0, 3'b000);
        do_op(MD_MFLO, 0, 0, 1, 1'b0, 1'b0, 3'b000);

        // Randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (op == MD_DIV || op == MD_DIVU) ? 32'($urandom_range(1, 1000)) : $urandom;
            do_op(op, a, b, $urandom_range(1, 6), !is_read(op) && ($urandom_range(0, 5) == 0),
                  1'b0, 3'b000);
        end

        // Watchdog: busy stuck high
        wait_ready();
        mdu_stuck = 1'b1;
        mdu_lat   = 1;
        req_valid = 1'b1;
        req_op    = MD_MULTU;
        req_srca  = 32'd9;
        req_srcb  = 32'd9;
        tick();
        req_valid = 1'b0;
        check("wdog_start", md_start, 1'b1);
        {exp_hi, exp_lo} = md_result(MD_MULTU, 32'd9, 32'd9, exp_hi, exp_lo);
        tick();
        n = 0;
        while (!req_ready && n < WDOG + 8) begin
            tick();
            n++;
        end
        check("wdog_window", (n >= WDOG) && (n <= WDOG + 1), 1'b1);
        check("wdog_err_set", wdog_err, 1'b1);
        mdu_stuck = 1'b0;
        tick();
        tick();
        do_op(MD_MFLO, 0, 0, 1, 1'b0, 1'b0, 3'b000);
        do_op(MD_MULT, 32'd3, 32'd4, 2, 1'b0, 1'b0, 3'b000);
        check("wdog_err_sticky", wdog_err, 1'b1);

        // Reset in the middle of a divide
        wait_ready();
        mdu_lat   = 8;
        req_valid = 1'b1;
        req_op    = MD_DIV;
        req_srca  = 32'd100;
        req_srcb  = 32'd7;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("div_in_wait", {req_ready, mdu_busy}, 2'b01);
        reset = 1'b0;
        #1;
        check("midwait_rst_ctrl", {req_ready, md_start, md_op, rd_valid, stall, wdog_err}, '0);
        check("midwait_rst_data", {md_srca, md_srcb, rd_data}, '0);
        exp_hi = '0;
        exp_lo = '0;
        #3 reset = 1'b1;
        tick();
        check("ready_after_rst", req_ready, 1'b1);
        do_op(MD_MFLO, 0, 0, 1, 1'b0, 1'b0, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
